// File: rtl/param_delay_timer.sv
// param_delay_timer
//   Programmable delay timer with one-shot and auto-reload modes.
//   Start latches Terminal/Periodic and begins counting ticks from 0. Done
//   rises T+1 ticks after the Start edge for a latched terminal T.
//
// Configuration macro:
//   DELAY_TIMER_PRESCALE_EN  when defined, a tick is every PRESCALE clocks
//                            while running; otherwise every running clock
//                            is a tick and PRESCALE is unused.
//
// Parameters:
//   WIDTH     counter / terminal width in bits
//   PRESCALE  clock cycles per tick (only with DELAY_TIMER_PRESCALE_EN)
//
// Ports:
//   ClockIn    in   single clock, all state on rising edge
//   Reset      in   asynchronous, active-high reset
//   Enable     in   run permission; low clears to IDLE synchronously
//   Start      in   single-cycle request: load Terminal/Periodic, begin
//   Periodic   in   0 = one-shot, 1 = auto-reload; sampled with Start
//   Terminal   in   terminal count; sampled with Start
//   Count      out  current count value
//   Busy       out  high while in RUN
//   Done       out  expiry: level in one-shot, one-clock pulse in periodic
//   dbg_state  out  current FSM state (IDLE=0, RUN=1, EXPIRED=2)
//
// Handshake: Start is a fire-and-forget request with no ready; it is
// accepted on any rising edge where Enable=1 and the timer is out of reset
// for at least one edge. Done carries no acknowledge; in one-shot it stays
// high until the next accepted Start or Enable=0.
module param_delay_timer #(
  parameter int WIDTH    = 11,
  parameter int PRESCALE = 1000
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Start,
  input  logic             Periodic,
  input  logic [WIDTH-1:0] Terminal,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_delay_timer: PRESCALE must be at least 1");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic             periodic_q;
  logic             done_q;
  logic             armed;
  logic             tick;
  logic             start_ok;

  // armed is low until the first edge after Reset releases, so a Start
  // coinciding with the reset-release edge is not taken.
  assign start_ok = Start && armed;

`ifdef DELAY_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  assign tick = (psc == PS_LAST);

  // Prescaler only advances in RUN; it is zeroed by every clear or restart,
  // and it wraps to 0 on the tick edge, so it is 0 whenever RUN is left.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      psc <= '0;
    end else if (!Enable || start_ok) begin
      psc <= '0;
    end else if (state == S_RUN) begin
      psc <= tick ? '0 : psc + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      count_q    <= '0;
      term_q     <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!Enable) begin
        // Enable low wins over everything, Start included.
        state   <= S_IDLE;
        count_q <= '0;
        done_q  <= 1'b0;
      end else if (start_ok) begin
        // Restart from any state; an aborted interval never pulses Done.
        term_q     <= Terminal;
        periodic_q <= Periodic;
        count_q    <= '0;
        done_q     <= 1'b0;
        state      <= S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            done_q <= 1'b0;
            if (tick) begin
              if (count_q == term_q) begin
                done_q <= 1'b1;
                if (periodic_q) begin
                  count_q <= '0;
                end else begin
                  // Count freezes at the terminal value.
                  state <= S_EXPIRED;
                end
              end else begin
                // count_q < term_q here, so this never wraps.
                count_q <= count_q + WIDTH'(1);
              end
            end
          end
          S_EXPIRED: begin
            done_q <= 1'b1;
          end
          S_IDLE: begin
            done_q <= 1'b0;
          end
          default: begin
            state   <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Count     = count_q;
  assign Busy      = (state == S_RUN);
  assign Done      = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_param_delay_timer.sv
// tb_param_delay_timer
//   Drives directed and random stimulus into param_delay_timer. For every
//   clock edge (and every asynchronous reset assertion) the expected
//   {Count, Busy, Done} is pushed into exp_q; a separate monitor pops and
//   compares after each DUT event.
//   Reference model: after an accepted Start with terminal T, n edges later
//   the number of ticks is k = n / P. One-shot: Count = min(k, T),
//   Done = (k > T), Busy = !Done. Periodic: Count = k mod (T+1),
//   Done on tick edges where k > 0 and k mod (T+1) == 0, Busy = 1.
module tb_param_delay_timer;

  localparam int W = 4;
`ifdef DELAY_TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  localparam int OW = W + 2;

  // Clock / reset
  logic         ClockIn = 1'b0;
  logic         Reset = 1'b1;
  logic         Enable = 1'b0;
  logic         Start = 1'b0;
  logic         Periodic = 1'b0;
  logic [W-1:0] Terminal = '0;
  logic [W-1:0] Count;
  logic         Busy;
  logic         Done;
  logic [1:0]   dbg_state;

  always #5 ClockIn = ~ClockIn;

  param_delay_timer #(.WIDTH(W), .PRESCALE(P)) dut (
    .ClockIn   (ClockIn),
    .Reset     (Reset),
    .Enable    (Enable),
    .Start     (Start),
    .Periodic  (Periodic),
    .Terminal  (Terminal),
    .Count     (Count),
    .Busy      (Busy),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_active = 1'b0;
  bit m_per = 1'b0;
  bit m_armed = 1'b0;
  int m_t = 0;
  int m_n = 0;

  function automatic void model_reset();
    m_active = 1'b0;
    m_per    = 1'b0;
    m_armed  = 1'b0;
    m_t      = 0;
    m_n      = 0;
  endfunction

  function automatic void model_edge(input bit e, input bit s, input bit p, input int t);
    if (!e) begin
      m_active = 1'b0;
    end else if (s && m_armed) begin
      m_active = 1'b1;
      m_n      = 0;
      m_t      = t;
      m_per    = p;
    end else if (m_active) begin
      m_n = m_n + 1;
    end
    m_armed = 1'b1;
  endfunction

  function automatic logic [OW-1:0] model_out();
    int k;
    int c;
    logic [W-1:0] cv;
    logic d;
    if (!m_active) return '0;
    k = m_n / P;
    if (!m_per) begin
      if (k > m_t) begin
        cv = W'(m_t);
        return {cv, 1'b0, 1'b1};
      end
      cv = W'(k);
      return {cv, 1'b1, 1'b0};
    end
    c  = k % (m_t + 1);
    d  = (k > 0) && (c == 0) && ((m_n % P) == 0);
    cv = W'(c);
    return {cv, 1'b1, d};
  endfunction

  // Driver tasks: called just after a falling edge
  task automatic cyc(input bit e, input bit s, input bit p, input int t);
    Enable   = e;
    Start    = s;
    Periodic = p;
    Terminal = W'(t);
    model_edge(e, s, p, t);
    exp_q.push_back(model_out());
    @(negedge ClockIn);
  endtask

  task automatic idle_cycles(input int n, input bit p, input int t);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, p, t);
  endtask

  // Reset asserted mid-cycle: one check right after assertion, one at the
  // clock edge it is held across, then released at the next falling edge.
  task automatic async_reset();
    Start = 1'b0;
    model_reset();
    exp_q.push_back('0);
    exp_q.push_back('0);
    #2 Reset = 1'b1;
    @(negedge ClockIn);
    Reset = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [OW-1:0] exp_v;
    logic [OW-1:0] got;
    forever begin
      @(posedge ClockIn or posedge Reset);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got   = {Count, Busy, Done};
        vectors++;
        if (got !== exp_v) begin
          miscompares++;
          $display("FAIL out_check t=%0t: got count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
                   $time, got[OW-1:2], got[1], got[0], exp_v[OW-1:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    model_reset();
    @(negedge ClockIn);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      @(negedge ClockIn);
    end
    Reset = 1'b0;

    // Start on the reset-release edge is ignored
    cyc(1'b1, 1'b1, 1'b0, 5);
    idle_cycles(2, 1'b0, 5);

    // One-shot, T=5
    cyc(1'b1, 1'b1, 1'b0, 5);
    idle_cycles(10 * P, 1'b1, 9);

    // Periodic, T=3
    cyc(1'b1, 1'b1, 1'b1, 3);
    idle_cycles(14 * P, 1'b0, 0);

    // Enable drop mid-run, then Start with Enable low
    cyc(1'b1, 1'b1, 1'b0, 10);
    idle_cycles(3 * P, 1'b0, 10);
    cyc(1'b0, 1'b0, 1'b0, 10);
    cyc(1'b0, 1'b1, 1'b0, 10);
    cyc(1'b0, 1'b1, 1'b1, 2);
    idle_cycles(3, 1'b0, 10);

    // Async reset mid-run at Count=7 (no prescale)
    cyc(1'b1, 1'b1, 1'b0, 12);
    idle_cycles(7 * P, 1'b0, 12);
    async_reset();
    cyc(1'b1, 1'b1, 1'b0, 3);
    cyc(1'b1, 1'b1, 1'b0, 3);
    idle_cycles(6 * P, 1'b0, 3);

    // Restart at Count=6 with new terminal 2
    cyc(1'b1, 1'b1, 1'b0, 9);
    idle_cycles(6 * P, 1'b0, 9);
    cyc(1'b1, 1'b1, 1'b0, 2);
    idle_cycles(6 * P, 1'b0, 9);

    // Restart while expired, periodic
    cyc(1'b1, 1'b1, 1'b1, 1);
    idle_cycles(7 * P, 1'b0, 9);

    // Full-range terminal: reaches all-ones then expires, no wrap
    cyc(1'b1, 1'b1, 1'b0, (1 << W) - 1);
    idle_cycles(((1 << W) + 3) * P, 1'b0, 0);

    // T=0 in both modes
    cyc(1'b1, 1'b1, 1'b0, 0);
    idle_cycles(3 * P, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, 0);
    idle_cycles(4 * P, 1'b0, 0);

    // Random: Terminal/Periodic wander while Start is low
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 29) != 0),
          ($urandom_range(0, 14) == 0),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 7));
    end

    // Drain
    cyc(1'b1, 1'b0, 1'b0, 0);
    @(negedge ClockIn);
    @(negedge ClockIn);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_delay_timer.md
PARAM_DELAY_TIMER -- requirements
Module: param_delay_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 11, counter and terminal width in bits.
REQ-002 SHALL have parameter PRESCALE, default 1000, clock cycles per tick; used only when DELAY_TIMER_PRESCALE_EN is defined.
REQ-003 SHALL have port ClockIn  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Enable  input  1  run permission; low = synchronous clear.
REQ-006 SHALL have port Start  input  1  single-cycle request to load Terminal and begin timing.
REQ-007 SHALL have port Periodic  input  1  mode select: 0 = one-shot, 1 = auto-reload; sampled with Start.
REQ-008 SHALL have port Terminal  input  WIDTH  terminal count; sampled with Start.
REQ-009 SHALL have port Count  output  WIDTH  current count value.
REQ-010 SHALL have port Busy  output  1  high in RUN state.
REQ-011 SHALL have port Done  output  1  expiry indication: level in one-shot, pulse in periodic.

Function
REQ-012 SHALL implement states IDLE, RUN and EXPIRED.
REQ-013 SHALL clear to IDLE with Count=0 and prescaler=0 on any edge where Enable=0; this overrides every other event, including Start.
REQ-014 SHALL, in any state with Enable=1 and Start=1, latch Terminal and Periodic, set Count=0 and prescaler=0, and enter RUN.
REQ-015 SHALL, in RUN on a tick edge, assert Done (EXPIRED) if Count equals the latched terminal; otherwise it SHALL increment Count.
REQ-016 SHALL hold Count unchanged on non-tick edges.
REQ-017 SHALL, in one-shot mode on expiry, enter EXPIRED, freeze Count at the terminal, and hold Done=1 until Start or Enable=0.
REQ-018 SHALL, in periodic mode on expiry, stay in RUN, set Count=0, and drive Done=1 for exactly one clock.
REQ-019 SHALL make Done rise exactly T+1 ticks after the Start edge for latched terminal T; T=0 gives expiry on the first tick.
REQ-020 SHALL never let Count exceed the latched terminal and never wrap past 2^WIDTH-1; with T=2^WIDTH-1, Count reaches all-ones and then expires.
REQ-021 SHALL ignore Terminal and Periodic changes while Start is low.
REQ-022 SHALL, on Start in RUN, restart cleanly with no Done pulse for the aborted interval.
REQ-023 SHALL drive Busy=1 only in RUN and Done=0 in IDLE and RUN, except for the periodic pulse.

Reset
REQ-024 SHALL, on Reset=1, immediately force IDLE, Count=0, Done=0, Busy=0, prescaler=0, latched terminal=0, and latched Periodic=0, independent of ClockIn.
REQ-025 SHALL take no Start during the edge on which Reset deasserts; the first Start is accepted on the next edge.

Configuration
REQ-026 SHALL, with DELAY_TIMER_PRESCALE_EN defined, include a prescaler counting 0..PRESCALE-1 in RUN; a tick occurs on the edge where the prescaler is PRESCALE-1, after which it wraps to 0.
REQ-027 SHALL, with DELAY_TIMER_PRESCALE_EN undefined, contain no prescaler and treat every RUN edge as a tick; PRESCALE is then unused.

Verification
REQ-028 SHALL cover one-shot: Periodic=0, Terminal=5, Start at edge 0, no prescale -> Done rises after edge 6, Count=5 held, Busy=0 from edge 6.
REQ-029 SHALL cover periodic: Periodic=1, Terminal=3 -> Done is a 1-cycle pulse after edges 4, 8 and 12, and Count follows 0,1,2,3,0.
REQ-030 SHALL cover Enable drop: Terminal=10, Enable=0 at edge 4 -> Count=0, IDLE, no Done; Start with Enable=0 -> stays IDLE.
REQ-031 SHALL cover async Reset mid-RUN at Count=7 -> all outputs 0 before the next ClockIn edge.
REQ-032 SHALL cover restart: Start again at Count=6 with new Terminal=2 -> Done after 3 further edges, no earlier pulse.
REQ-033 SHALL cover prescale, with DELAY_TIMER_PRESCALE_EN defined, PRESCALE=4 and Terminal=1 -> Done rises 8 edges after Start.
